// File: rtl/golden_nonce_sequencer_pkg.sv
// Shared widths, hash word-slice macro and issue-state payload for the golden nonce sequencer.
`ifndef GOLDEN_NONCE_SEQUENCER_IDX
`define GOLDEN_NONCE_SEQUENCER_IDX
`define IDX(w) ((w)*32+31):((w)*32)
`endif

package golden_nonce_sequencer_pkg;

   localparam int unsigned NONCE_W = 32;
   localparam int unsigned HASH_W  = 256;
   localparam int unsigned CNT_W   = 6;
   localparam int unsigned WORD_W  = 32;

   typedef logic [NONCE_W-1:0] nonce_t;

   // Everything presented to the hasher chain in one cycle.
   typedef struct packed {
      logic [CNT_W-1:0] cnt;
      logic             feedback;
      nonce_t           nonce;
   } issue_t;

   function automatic logic word_le(input logic [WORD_W-1:0] a, input logic [WORD_W-1:0] b);
      return a <= b;
   endfunction

endpackage

// File: rtl/golden_fifo.sv
// Synchronous first-word-fall-through FIFO; head is always entry 0, so every output is a flop.
module golden_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty,
   output logic             valid
);

   localparam int unsigned OCC_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_n [DEPTH];
   logic [OCC_W-1:0] count_q;
   logic [OCC_W-1:0] count_n;
   logic [OCC_W-1:0] wr_idx;
   logic             do_push;
   logic             do_pop;

   // A full FIFO still accepts a push when the same cycle frees a slot.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign wr_idx  = do_pop ? count_q - OCC_W'(1) : count_q;
   assign head    = mem_q[0];

   always_comb begin
      mem_n   = mem_q;
      count_n = count_q;
      if (do_pop) begin
         for (int i = 0; i < DEPTH - 1; i++) begin
            mem_n[i] = mem_q[i+1];
         end
         mem_n[DEPTH-1] = '0;
         count_n        = count_n - OCC_W'(1);
      end
      if (do_push) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (wr_idx == OCC_W'(i)) begin
               mem_n[i] = wdata;
            end
         end
         count_n = count_n + OCC_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_q   <= '{default: '0};
         count_q <= '0;
         full    <= 1'b0;
         empty   <= 1'b1;
         valid   <= 1'b0;
      end else begin
         mem_q   <= mem_n;
         count_q <= count_n;
         full    <= (count_n == OCC_W'(DEPTH));
         empty   <= (count_n == '0);
         valid   <= (count_n != '0);
      end
   end

endmodule

// File: rtl/golden_nonce_sequencer.sv
// Drives cnt/feedback/nonce into the double-SHA-256 chain and queues nonces whose final hash
// meets the target.
module golden_nonce_sequencer
   import golden_nonce_sequencer_pkg::*;
#(
   parameter int unsigned LOOP       = 4,
   parameter int unsigned NONCE_LAG  = 34,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               work_load,
   input  logic [NONCE_W-1:0] nonce_start,
   input  logic [WORD_W-1:0]  target,
   input  logic [HASH_W-1:0]  hash_in,
   output logic [CNT_W-1:0]   cnt,
   output logic               feedback,
   output logic [NONCE_W-1:0] nonce,
   output logic               golden_valid,
   output logic [NONCE_W-1:0] golden_nonce,
   input  logic               golden_ready,
   output logic               overflow,
   output logic               exhausted
);

   localparam int unsigned     WARM_W    = (NONCE_LAG < 1) ? 1 : $clog2(NONCE_LAG + 1);
   localparam logic [CNT_W-1:0]  LOOP_LAST = CNT_W'(LOOP - 1);
   localparam logic [WARM_W-1:0] WARM_FULL = WARM_W'(NONCE_LAG);
   localparam nonce_t            LAG       = NONCE_W'(NONCE_LAG);

   issue_t            issue_q;
   issue_t            issue_n;
   logic [WARM_W-1:0] warm_q;
   logic [WARM_W-1:0] warm_n;
   logic              exhausted_n;
   logic              overflow_n;
   logic              slot_wrap;
   logic              check;
   logic              match;
   logic              push;
   logic              pop;
   logic              fifo_full;
   logic              fifo_empty;
   nonce_t            golden_in;
   logic              unused_hash;

   assign unused_hash = ^hash_in[HASH_W-WORD_W-1:0];

   // The hash on hash_in at cnt==0 belongs to the nonce issued NONCE_LAG slots ago.
   assign slot_wrap = (issue_q.cnt == LOOP_LAST);
   assign match     = word_le(hash_in[`IDX(7)], target);
   assign check     = !work_load && (issue_q.cnt == '0) && (warm_q == WARM_FULL);
   assign push      = check && match;
   assign pop       = golden_ready && !fifo_empty;
   assign golden_in = issue_q.nonce - LAG;

   always_comb begin
      issue_n     = issue_q;
      warm_n      = warm_q;
      exhausted_n = exhausted;
      overflow_n  = overflow;
      if (push && fifo_full && !pop) begin
         overflow_n = 1'b1;
      end
      if (work_load) begin
         issue_n.cnt      = '0;
         issue_n.feedback = 1'b0;
         issue_n.nonce    = nonce_start;
         warm_n           = '0;
         exhausted_n      = 1'b0;
      end else begin
         issue_n.cnt      = slot_wrap ? '0 : issue_q.cnt + CNT_W'(1);
         issue_n.feedback = !slot_wrap;
         if (slot_wrap) begin
            issue_n.nonce = issue_q.nonce + NONCE_W'(1);
            if (&issue_q.nonce) begin
               exhausted_n = 1'b1;
            end
            if (warm_q != WARM_FULL) begin
               warm_n = warm_q + WARM_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         issue_q   <= '0;
         warm_q    <= '0;
         exhausted <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         issue_q   <= issue_n;
         warm_q    <= warm_n;
         exhausted <= exhausted_n;
         overflow  <= overflow_n;
      end
   end

   assign cnt      = issue_q.cnt;
   assign feedback = issue_q.feedback;
   assign nonce    = issue_q.nonce;

   golden_fifo #(
      .WIDTH (NONCE_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .wdata (golden_in),
      .pop   (pop),
      .head  (golden_nonce),
      .full  (fifo_full),
      .empty (fifo_empty),
      .valid (golden_valid)
   );

endmodule

// File: doc/golden_nonce_sequencer.md
# golden_nonce_sequencer

Sequencer and result collector wrapped around the double-SHA-256 hasher chain. Drives the shared loop counter (`cnt`) and `feedback` into both transforms. Issues one candidate nonce per LOOP cycles and inspects the final hash on the matching slot. Reconstructs the nonce that produced each winning hash and queues it in a small FIFO for the host interface under a valid/ready handshake.

## Interface
Parameters:
- `LOOP`, 4 — cycles per issue slot; must equal the hashers' LOOP, power of two, 1..32.
- `NONCE_LAG`, 34 — issue slots between a nonce being presented and its final hash appearing on `hash_in`. The integrator sets this from the chain depth.
- `FIFO_DEPTH`, 4 — golden-nonce queue entries, power of two ≥ 2.

Ports:
- `clk` in 1 — sole clock.
- `reset` in 1 — synchronous, active-high.
- `work_load` in 1 — one-cycle pulse; start new work at `nonce_start`.
- `nonce_start` in 32 — first nonce of new work.
- `target` in 32 — match threshold for the top hash word.
- `hash_in` in 256 — registered final hash from the second transform.
- `cnt` out 6 — loop counter to both transforms.
- `feedback` out 1 — 0 on the load cycle of a slot, 1 otherwise.
- `nonce` out 32 — nonce presented to the first transform.
- `golden_valid` out 1 — FIFO non-empty.
- `golden_nonce` out 32 — FIFO head.
- `golden_ready` in 1 — host accepts head.
- `overflow` out 1 — sticky; a match was dropped.
- `exhausted` out 1 — sticky; nonce wrapped past 0xFFFFFFFF.

## Operation
- Slot counter `cnt` runs 0..LOOP-1 and wraps. `feedback = (cnt != 0)`, registered together with `cnt`.
- `nonce` increments by 1 (mod 2^32) on the cycle `cnt` wraps to 0. It is stable for the whole slot.
  - Increment from 0xFFFFFFFF to 0 sets `exhausted`.
  - Hashing continues after the wrap.
- Warm-up counter counts issued slots up to NONCE_LAG and saturates there. Checking is enabled only when the counter is saturated.
- Check happens on each `cnt == 0` cycle with checking enabled.
  - Match condition: `hash_in[255:224] <= target`, unsigned.
  - On a match, push `nonce - NONCE_LAG` (mod 2^32) into the FIFO.
- FIFO has FIFO_DEPTH entries and is first-word fall-through.
  - Pop when `golden_valid && golden_ready`.
  - Push while full with no pop in the same cycle: the entry is dropped and `overflow` is set.
  - Push and pop in the same cycle while full: both take effect, occupancy unchanged.
  - Push and pop in the same cycle while empty: the entry is pushed, nothing is popped.
- `work_load` (takes priority over everything except `reset`):
  - Next cycle: `cnt = 0`, `feedback = 0`, `nonce = nonce_start`.
  - Warm-up counter is cleared, so old in-flight hashes are never checked.
  - `exhausted` is cleared.
  - FIFO and `overflow` are kept; already-found results stay valid.
  - A check due in the same cycle as `work_load` is suppressed.

## Timing
- Reset values: `cnt` = 0, `feedback` = 0, `nonce` = 0, `golden_valid` = 0, `golden_nonce` = 0, `overflow` = 0, `exhausted` = 0. FIFO empty, warm-up counter 0.
- Reset mid-operation discards FIFO contents and stickies in the same cycle.
- All outputs are registered.
- Match to `golden_valid`: 1 cycle after the `cnt == 0` sample.
- Pop to next head: visible 1 cycle after the handshake.
- First checkable slot after reset or `work_load`: NONCE_LAG·LOOP cycles later.

## Structure
- Shared package holds the `IDX` word-slice define and the width constants: nonce 32, hash 256, cnt 6.
- One sub-module, `golden_fifo`: synchronous FWFT FIFO with `full`/`empty`, parameterised width and depth. It is reusable for the host UART path.
- Top-level logic is the slot counter, nonce counter, warm-up counter, comparator and sticky flags.

## Test plan
Bench parameters: LOOP=4, NONCE_LAG=3, FIFO_DEPTH=4.
- Reset, then free-run. Expect `cnt` to cycle 0,1,2,3 with `feedback` = 0,1,1,1 and `nonce` to step 0,1,2… every 4 cycles.
- `work_load` with `nonce_start` = 0x100, `target` = 0. Drive top word 0 only in the slot where `nonce` = 0x105. Expect `golden_nonce` = 0x102 one cycle later. No push during the first 3 slots even if top word = 0.
- Five consecutive matches with `golden_ready` = 0. Expect 4 entries queued in order and `overflow` = 1. Raise `golden_ready`: 4 pops in order, then `golden_valid` = 0.
- FIFO full, match and pop in the same cycle. Expect occupancy to stay at 4, the new entry to be at the tail, and `overflow` to stay 0.
- `nonce_start` = 0xFFFFFFFE, let it run. Expect `nonce` to wrap to 0 and `exhausted` = 1. A following `work_load` clears `exhausted`.
- `reset` asserted while the FIFO holds 2 entries and `overflow` = 1. Expect all outputs at reset values the next cycle.
